// File: rtl/isr_code_encoder_pkg.sv
// Shared definitions for the interrupt code encoder and the current-ISR decoder.
//
// Contents:
//   ISR_* code constants : 3-bit current/pending ISR codes (7 is never used)
//   isr_state_t          : encoder FSM state encoding
//   is_fast_code()       : true for the fast-class codes 4..6
package isr_defs;

  localparam logic [2:0] ISR_NONE  = 3'd0;
  localparam logic [2:0] ISR_N_IO2 = 3'd1;
  localparam logic [2:0] ISR_N_IO1 = 3'd2;
  localparam logic [2:0] ISR_N_IO0 = 3'd3;
  localparam logic [2:0] ISR_F_IO2 = 3'd4;
  localparam logic [2:0] ISR_F_IO1 = 3'd5;
  localparam logic [2:0] ISR_F_IO0 = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_SVC_N  = 3'd2,
    ST_PEND_F = 3'd3,
    ST_SVC_F  = 3'd4
  } isr_state_t;

  function automatic logic is_fast_code(input logic [2:0] code);
    return (code >= ISR_F_IO2) && (code <= ISR_F_IO0);
  endfunction

endpackage

// File: rtl/isr_prio_enc.sv
// Combinational priority encoder for already-masked interrupt requests.
// Any fast request beats any normal one; within a class IO2 > IO1 > IO0.
//
// Ports:
//   nirq  in  [2:0] masked normal requests ([2]=IO2 .. [0]=IO0)
//   firq  in  [2:0] masked fast requests (same mapping)
//   code  out [2:0] winning ISR code, ISR_NONE when nothing is requesting
//   valid out       at least one request present
module isr_prio_enc
  import isr_defs::*;
(
  input  logic [2:0] nirq,
  input  logic [2:0] firq,
  output logic [2:0] code,
  output logic       valid
);

  always_comb begin
    code = ISR_NONE;
    if      (firq[2]) code = ISR_F_IO2;
    else if (firq[1]) code = ISR_F_IO1;
    else if (firq[0]) code = ISR_F_IO0;
    else if (nirq[2]) code = ISR_N_IO2;
    else if (nirq[1]) code = ISR_N_IO1;
    else if (nirq[0]) code = ISR_N_IO0;
  end

  assign valid = (|nirq) | (|firq);

endmodule

// File: rtl/isr_code_encoder.sv
// Interrupt request arbiter and current-ISR code generator for IO0/IO1/IO2.
// Raises one prioritized request to the CPU, tracks the ack/done handshake,
// supports one level of fast-over-normal preemption and drives the current
// ISR code consumed by the current-ISR decoder. All outputs are registered.
//
// Ports:
//   clk       in        system clock, rising edge
//   reset     in        asynchronous active-high reset
//   nirq      in  [2:0] normal requests, level ([2]=IO2 .. [0]=IO0)
//   firq      in  [2:0] fast requests, level (same mapping)
//   nirq_en   in        global enable for normal requests
//   firq_en   in        global enable for fast requests
//   isr_ack   in        CPU pulse: pending request has been vectored
//   isr_done  in        CPU pulse: return-from-interrupt executed
//   int_req   out       interrupt request to the CPU
//   pend_code out [2:0] pending request code (0 when int_req is low)
//   cur_isr   out [2:0] code of the executing ISR (0 = none)
//   nested    out       fast ISR running on top of a preempted normal ISR
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | nothing pending or running; arbitrate enabled requests
// ST_PEND   | int_req high, pend_code frozen, no ISR running
// ST_SVC_N  | normal ISR running; an enabled fast request may preempt it
// ST_PEND_F | normal ISR running, fast request pending (int_req high)
// ST_SVC_F  | fast ISR running, possibly nested over a saved normal ISR
module isr_code_encoder
  import isr_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] nirq,
  input  logic [2:0] firq,
  input  logic       nirq_en,
  input  logic       firq_en,
  input  logic       isr_ack,
  input  logic       isr_done,
  output logic       int_req,
  output logic [2:0] pend_code,
  output logic [2:0] cur_isr,
  output logic       nested
);

  isr_state_t state, state_n;
  logic [2:0] save_code, save_code_n;
  logic       save_valid, save_valid_n;
  logic       int_req_n;
  logic [2:0] pend_code_n;
  logic [2:0] cur_isr_n;
  logic       nested_n;

  logic [2:0] nirq_m;
  logic [2:0] firq_m;
  logic [2:0] win_code;
  logic       win_valid;
  logic       fast_any;

  assign nirq_m   = nirq & {3{nirq_en}};
  assign firq_m   = firq & {3{firq_en}};
  // With a fast request present the encoder winner is always the fast code.
  assign fast_any = |firq_m;

  isr_prio_enc u_prio_enc (
    .nirq  (nirq_m),
    .firq  (firq_m),
    .code  (win_code),
    .valid (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      save_code  <= ISR_NONE;
      save_valid <= 1'b0;
      int_req    <= 1'b0;
      pend_code  <= ISR_NONE;
      cur_isr    <= ISR_NONE;
      nested     <= 1'b0;
    end else begin
      state      <= state_n;
      save_code  <= save_code_n;
      save_valid <= save_valid_n;
      int_req    <= int_req_n;
      pend_code  <= pend_code_n;
      cur_isr    <= cur_isr_n;
      nested     <= nested_n;
    end
  end

  always_comb begin
    state_n      = state;
    save_code_n  = save_code;
    save_valid_n = save_valid;
    int_req_n    = int_req;
    pend_code_n  = pend_code;
    cur_isr_n    = cur_isr;
    nested_n     = nested;

    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          pend_code_n = win_code;
          int_req_n   = 1'b1;
          state_n     = ST_PEND;
        end
      end

      // isr_done is ignored here, so a same-cycle ack/done takes the ack.
      ST_PEND: begin
        if (isr_ack) begin
          cur_isr_n   = pend_code;
          pend_code_n = ISR_NONE;
          int_req_n   = 1'b0;
          state_n     = is_fast_code(pend_code) ? ST_SVC_F : ST_SVC_N;
        end
      end

      ST_SVC_N: begin
        if (isr_done) begin
          cur_isr_n = ISR_NONE;
          state_n   = ST_IDLE;
        end else if (fast_any) begin
          pend_code_n = win_code;
          int_req_n   = 1'b1;
          state_n     = ST_PEND_F;
        end
      end

      // Ack has priority over a coincident done.
      ST_PEND_F: begin
        if (isr_ack) begin
          save_code_n  = cur_isr;
          save_valid_n = 1'b1;
          cur_isr_n    = pend_code;
          pend_code_n  = ISR_NONE;
          int_req_n    = 1'b0;
          nested_n     = 1'b1;
          state_n      = ST_SVC_F;
        end else if (isr_done) begin
          // Normal ISR finished before the fast one was vectored.
          cur_isr_n = ISR_NONE;
          state_n   = ST_PEND;
        end
      end

      ST_SVC_F: begin
        if (isr_done) begin
          if (save_valid) begin
            cur_isr_n    = save_code;
            save_code_n  = ISR_NONE;
            save_valid_n = 1'b0;
            nested_n     = 1'b0;
            state_n      = ST_SVC_N;
          end else begin
            cur_isr_n = ISR_NONE;
            state_n   = ST_IDLE;
          end
        end
      end

      default: begin
        state_n      = ST_IDLE;
        save_code_n  = ISR_NONE;
        save_valid_n = 1'b0;
        int_req_n    = 1'b0;
        pend_code_n  = ISR_NONE;
        cur_isr_n    = ISR_NONE;
        nested_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_isr_code_encoder.sv
module tb_isr_code_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] nirq = '0;
  logic [2:0] firq = '0;
  logic       nirq_en = 1'b0;
  logic       firq_en = 1'b0;
  logic       isr_ack = 1'b0;
  logic       isr_done = 1'b0;
  logic       int_req;
  logic [2:0] pend_code;
  logic [2:0] cur_isr;
  logic       nested;

  int tests_run = 0;
  int tests_failed = 0;

  isr_code_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .nirq      (nirq),
    .firq      (firq),
    .nirq_en   (nirq_en),
    .firq_en   (firq_en),
    .isr_ack   (isr_ack),
    .isr_done  (isr_done),
    .int_req   (int_req),
    .pend_code (pend_code),
    .cur_isr   (cur_isr),
    .nested    (nested)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: pending request, running ISR and a stack of preempted ISRs.
  logic [2:0] m_pend;
  logic [2:0] m_cur;
  logic [2:0] m_stack[$];

  function automatic logic [2:0] arbitrate(input logic [2:0] n, input logic [2:0] f,
                                           input logic ne, input logic fe, input bit fast_only);
    for (int i = 2; i >= 0; i--)
      if (fe && f[i]) return 3'(4 + (2 - i));
    if (!fast_only)
      for (int i = 2; i >= 0; i--)
        if (ne && n[i]) return 3'(1 + (2 - i));
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_pend = 3'd0;
    m_cur  = 3'd0;
    m_stack.delete();
  endtask

  task automatic model_step();
    logic [2:0] w;
    if (m_pend != 0) begin
      if (isr_ack) begin
        if (m_cur != 0) m_stack.push_back(m_cur);
        m_cur  = m_pend;
        m_pend = 3'd0;
      end else if (isr_done && m_cur != 0) begin
        m_cur = 3'd0;
      end
    end else if (m_cur == 0) begin
      m_pend = arbitrate(nirq, firq, nirq_en, firq_en, 1'b0);
    end else if (isr_done) begin
      if (m_stack.size() > 0) m_cur = m_stack.pop_back();
      else m_cur = 3'd0;
    end else if (m_cur <= 3) begin
      w = arbitrate(nirq, firq, nirq_en, firq_en, 1'b1);
      if (w != 0) m_pend = w;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    nirq = '0; firq = '0; nirq_en = 1'b1; firq_en = 1'b1;
    isr_ack = 1'b0; isr_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_ack();
    isr_ack = 1'b1; tick(); isr_ack = 1'b0;
  endtask

  task automatic pulse_done();
    isr_done = 1'b1; tick(); isr_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({int_req, pend_code, cur_isr, nested} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got int_req=%b pend=%0d cur=%0d nested=%b, want all 0",
               int_req, pend_code, cur_isr, nested);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    nirq = 3'b011; tick();
    tests_run++;
    if (int_req !== 1'b1 || pend_code !== 3'd2) begin
      tests_failed++;
      $display("FAIL simul_pend: got int_req=%b pend=%0d, want 1/2", int_req, pend_code);
    end
    nirq = 3'b001; pulse_ack();
    tests_run++;
    if (cur_isr !== 3'd2 || int_req !== 1'b0 || pend_code !== 3'd0) begin
      tests_failed++;
      $display("FAIL simul_ack: got cur=%0d int_req=%b pend=%0d, want 2/0/0", cur_isr, int_req, pend_code);
    end
    pulse_done();
    tests_run++;
    if (cur_isr !== 3'd0 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_done_gap: got cur=%0d int_req=%b, want 0/0", cur_isr, int_req);
    end
    tick();
    tests_run++;
    if (int_req !== 1'b1 || pend_code !== 3'd3) begin
      tests_failed++;
      $display("FAIL simul_rereq: got int_req=%b pend=%0d, want 1/3", int_req, pend_code);
    end
  endtask

  task automatic test_fast_over_normal();
    do_reset();
    nirq = 3'b100; firq = 3'b001; tick();
    tests_run++;
    if (int_req !== 1'b1 || pend_code !== 3'd6) begin
      tests_failed++;
      $display("FAIL fast_pend: got int_req=%b pend=%0d, want 1/6", int_req, pend_code);
    end
    nirq = 3'b000; firq = 3'b000; pulse_ack();
    tests_run++;
    if (cur_isr !== 3'd6 || nested !== 1'b0) begin
      tests_failed++;
      $display("FAIL fast_ack: got cur=%0d nested=%b, want 6/0", cur_isr, nested);
    end
  endtask

  task automatic reach_nested();
    do_reset();
    nirq = 3'b100; tick();
    nirq = 3'b000; pulse_ack();
    firq = 3'b010; tick();
    firq = 3'b000; pulse_ack();
  endtask

  task automatic test_preempt();
    do_reset();
    nirq = 3'b100; tick();
    nirq = 3'b000; pulse_ack();
    tests_run++;
    if (cur_isr !== 3'd1) begin
      tests_failed++;
      $display("FAIL preempt_svc_n: got cur=%0d, want 1", cur_isr);
    end
    firq = 3'b010; tick();
    tests_run++;
    if (int_req !== 1'b1 || pend_code !== 3'd5 || cur_isr !== 3'd1) begin
      tests_failed++;
      $display("FAIL preempt_pend: got int_req=%b pend=%0d cur=%0d, want 1/5/1", int_req, pend_code, cur_isr);
    end
    firq = 3'b000; pulse_ack();
    tests_run++;
    if (cur_isr !== 3'd5 || nested !== 1'b1 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL preempt_ack: got cur=%0d nested=%b int_req=%b, want 5/1/0", cur_isr, nested, int_req);
    end
    pulse_done();
    tests_run++;
    if (cur_isr !== 3'd1 || nested !== 1'b0) begin
      tests_failed++;
      $display("FAIL preempt_restore: got cur=%0d nested=%b, want 1/0", cur_isr, nested);
    end
    pulse_done();
    tests_run++;
    if (cur_isr !== 3'd0) begin
      tests_failed++;
      $display("FAIL preempt_final: got cur=%0d, want 0", cur_isr);
    end
  endtask

  task automatic test_normal_first();
    do_reset();
    nirq = 3'b001; tick();
    nirq = 3'b000; pulse_ack();
    firq = 3'b100; tick();
    tests_run++;
    if (pend_code !== 3'd4 || int_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL nfirst_pend: got pend=%0d int_req=%b, want 4/1", pend_code, int_req);
    end
    firq = 3'b000; pulse_done();
    tests_run++;
    if (cur_isr !== 3'd0 || int_req !== 1'b1 || pend_code !== 3'd4) begin
      tests_failed++;
      $display("FAIL nfirst_done: got cur=%0d int_req=%b pend=%0d, want 0/1/4", cur_isr, int_req, pend_code);
    end
    pulse_ack();
    tests_run++;
    if (cur_isr !== 3'd4 || nested !== 1'b0) begin
      tests_failed++;
      $display("FAIL nfirst_ack: got cur=%0d nested=%b, want 4/0", cur_isr, nested);
    end
  endtask

  task automatic test_mask_freeze();
    int seen_req;
    do_reset();
    nirq_en = 1'b0; nirq = 3'b111;
    seen_req = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_req !== 1'b0) seen_req++;
    end
    tests_run++;
    if (seen_req != 0) begin
      tests_failed++;
      $display("FAIL mask_hold: int_req high in %0d of 10 cycles, want 0", seen_req);
    end
    nirq_en = 1'b1; tick();
    tests_run++;
    if (int_req !== 1'b1 || pend_code !== 3'd1) begin
      tests_failed++;
      $display("FAIL mask_release: got int_req=%b pend=%0d, want 1/1", int_req, pend_code);
    end
    nirq = 3'b000; nirq_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (int_req !== 1'b1 || pend_code !== 3'd1) begin
        tests_failed++;
        $display("FAIL freeze_cycle%0d: got int_req=%b pend=%0d, want 1/1", i, int_req, pend_code);
      end
    end
    pulse_ack();
    tests_run++;
    if (cur_isr !== 3'd1) begin
      tests_failed++;
      $display("FAIL freeze_ack: got cur=%0d, want 1", cur_isr);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    reach_nested();
    tests_run++;
    if (nested !== 1'b1 || cur_isr !== 3'd5) begin
      tests_failed++;
      $display("FAIL rstmid_setup: got nested=%b cur=%0d, want 1/5", nested, cur_isr);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({int_req, pend_code, cur_isr, nested} !== 8'h00) begin
      tests_failed++;
      $display("FAIL rstmid_async: got int_req=%b pend=%0d cur=%0d nested=%b, want all 0",
               int_req, pend_code, cur_isr, nested);
    end
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({int_req, pend_code, cur_isr, nested} !== 8'h00) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rstmid_idle: outputs nonzero in %0d of 5 cycles, want 0", bad);
    end
    // A done here must not resurrect the discarded preempted ISR.
    pulse_done();
    tests_run++;
    if (cur_isr !== 3'd0 || nested !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_no_restore: got cur=%0d nested=%b, want 0/0", cur_isr, nested);
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    model_reset();
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      tests_run++;
      if (int_req !== (m_pend != 0) || pend_code !== m_pend || cur_isr !== m_cur ||
          nested !== (m_stack.size() != 0)) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_c%0d: got req=%b pend=%0d cur=%0d nest=%b, want req=%b pend=%0d cur=%0d nest=%b",
                   c, int_req, pend_code, cur_isr, nested,
                   (m_pend != 0), m_pend, m_cur, (m_stack.size() != 0));
      end
      nirq     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      firq     = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      nirq_en  = ($urandom_range(0, 7) != 0);
      firq_en  = ($urandom_range(0, 7) != 0);
      isr_ack  = ($urandom_range(0, 3) == 0);
      isr_done = ($urandom_range(0, 4) == 0);
      model_step();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_fast_over_normal();
    test_preempt();
    test_normal_first();
    test_mask_freeze();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
